// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  localparam int MST_CPU = 0;
  localparam int MST_DMA = 1;

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response port of one memory master (cpu or dma) facing the arbiter.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              stall;

  modport master (output req, we, addr, wdata, input rdata, ack, stall);
  modport slave  (input req, we, addr, wdata, output rdata, ack, stall);
endinterface

// File: rtl/dmem_arb_prio.sv
// Fixed cpu-first priority with a starvation bound that forces a dma grant.
module dmem_arb_prio import dmem_arb_pkg::*; #(
  parameter int DMA_MAX_WAIT = 4
)(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic [3:0] wait_cnt,
  output logic [1:0] grant,
  output logic [3:0] wait_nxt
);
  logic [1:0] elig;
  logic       dma_force;

  assign elig      = req & ~mask;
  assign dma_force = elig[MST_DMA] && (wait_cnt == 4'(DMA_MAX_WAIT));

  always_comb begin
    grant    = '0;
    wait_nxt = wait_cnt;
    if (elig[MST_CPU] && !dma_force) grant[MST_CPU] = 1'b1;
    else if (elig[MST_DMA])          grant[MST_DMA] = 1'b1;
    // only a contested cpu win counts against dma
    if (grant[MST_DMA])
      wait_nxt = '0;
    else if (grant[MST_CPU] && elig[MST_DMA] && (wait_cnt < 4'(DMA_MAX_WAIT)))
      wait_nxt = wait_cnt + 4'd1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM-stage port and the DMA port:
// grant edge, one access cycle, one ack cycle; pipeline stall derived from the ack.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DMA_MAX_WAIT = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dma,
  output logic              mem_wen,
  output logic              mem_readEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  arb_state_e                  state;
  cmd_t                        cmd;
  logic [1:0]                  req, acc, served, grant;
  logic [3:0]                  wait_cnt, wait_nxt;
  logic [1:0][DATA_W-1:0]      rdata_q;

  assign req = {dma.req, cpu.req};
  assign acc = {state == DMA_ACC, state == CPU_ACC};

  // a master is blind to the arbiter during its access cycle and its ack cycle
  dmem_arb_prio #(.DMA_MAX_WAIT(DMA_MAX_WAIT)) u_prio (
    .req      (req),
    .mask     (acc | served),
    .wait_cnt (wait_cnt),
    .grant    (grant),
    .wait_nxt (wait_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd      <= '0;
      served   <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      served   <= acc;
      wait_cnt <= wait_nxt;
      for (int m = 0; m < 2; m++)
        if (acc[m] && !cmd.we) rdata_q[m] <= mem_dataOut;
      if (grant[MST_CPU]) begin
        state <= CPU_ACC;
        cmd   <= '{we: cpu.we, addr: cpu.addr, wdata: cpu.wdata};
      end else if (grant[MST_DMA]) begin
        state <= DMA_ACC;
        cmd   <= '{we: dma.we, addr: dma.addr, wdata: dma.wdata};
      end else begin
        state <= IDLE;
      end
    end
  end

  // enables gated by reset so an abandoned access never commits
  assign mem_wen    = rst_n & (|acc) &  cmd.we;
  assign mem_readEn = rst_n & (|acc) & ~cmd.we;
  assign mem_addr   = cmd.addr;
  assign mem_dataIn = cmd.wdata;

  assign cpu.rdata = rdata_q[MST_CPU];
  assign cpu.ack   = served[MST_CPU];
  assign cpu.stall = cpu.req & ~served[MST_CPU];
  assign dma.rdata = rdata_q[MST_DMA];
  assign dma.ack   = served[MST_DMA];
  assign dma.stall = dma.req & ~served[MST_DMA];
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master controller in front of the single-port 32x32 data memory of the pipelined MIPS core. It shares the memory between the MEM-stage load/store port (cpu) and a loader/debug DMA port (dma). It sequences each access through a registered grant/access/acknowledge cycle and produces the pipeline stall. Fixed cpu priority applies, with a starvation bound for dma.

Parameters:
ADDR_W, 5, word address width (32 words)
DATA_W, 32, data width
DMA_MAX_WAIT, 4, consecutive contested cpu wins after which dma is granted next; range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  cpu access request, held until cpu_ack
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  cpu word address
cpu_wdata  in  DATA_W  cpu store data
cpu_rdata  out  DATA_W  load data, valid when cpu_ack=1, held until next cpu read ack
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same meaning as cpu_* for dma
mem_wen  out  1  to memory write enable
mem_readEn  out  1  to memory read enable
mem_addr  out  ADDR_W  to memory address
mem_dataIn  out  DATA_W  to memory write data
mem_dataOut  in  DATA_W  from memory, combinational read data

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; cmd regs, cpu_rdata, dma_rdata, acks, wait counter, served mask all 0.
- mem_wen/mem_readEn are gated combinationally with rst_n, so no write commits in a reset cycle.
- FSM states: IDLE, CPU_ACC, DMA_ACC.
- Decision point: at every edge in IDLE and at the edge ending *_ACC.
  - Eligible = req & ~masked.
  - cpu wins when eligible, unless dma is eligible and wait_cnt==DMA_MAX_WAIT.
  - Winner's we/addr/wdata are latched into the cmd reg; next state = winner's ACC, else IDLE.
- Masking: the requester served by an ACC state is ignored at the decision ending that ACC and at the next edge (its ack cycle). It is re-eligible one cycle after its ack.
  - Consequence: same-master throughput is one access per 3 cycles; alternating masters can run back-to-back.
- ACC cycle:
  - mem_addr/mem_dataIn = cmd; mem_wen = cmd_we; mem_readEn = ~cmd_we.
  - The write commits at the edge ending ACC.
  - For a read, mem_dataOut is captured into the served *_rdata at that edge.
  - The served *_ack is 1 for exactly the following cycle.
- Outside ACC: mem_wen = mem_readEn = 0; mem_addr and mem_dataIn hold their last value.
- Latency from req high in IDLE: grant edge, ACC cycle, ack in the 2nd cycle after req is sampled. cpu_stall is 1 for 2 cycles per uncontended access.
- wait_cnt (4 bits):
  - Increments at a decision where both are eligible and cpu wins.
  - Clears when dma is granted.
  - Saturates at DMA_MAX_WAIT.
  - Unchanged otherwise.
- A req dropped after grant does not abort: the access completes and ack still pulses.
- Requester fields are don't-care after their grant edge.
- Reset mid-ACC: the access is abandoned, with no commit and no ack; the requester must re-request.
- Addresses wrap naturally within ADDR_W; there is no range check.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state enum {IDLE, CPU_ACC, DMA_ACC}
  - master-id constants MST_CPU=0, MST_DMA=1
  - ADDR_W/DATA_W defaults
- One natural sub-module, dmem_arb_prio: eligible reqs, mask and wait_cnt in; grant one-hot and next wait_cnt out.
- FSM, cmd register and read capture stay in the top.

Test Plan:
- cpu store addr 3 data 0xDEADBEEF, then cpu load addr 3:
  - cpu_ack at cycle 2 after each req.
  - cpu_rdata=0xDEADBEEF on the load ack.
  - mem_wen high for exactly 1 cycle.
- cpu and dma both request in the same IDLE cycle:
  - cpu ACC first, dma ACC the next cycle.
  - cpu_ack and dma_ack in consecutive cycles.
  - dma_stall-equivalent wait is exactly 1 cycle.
- cpu_req held high continuously, dma_req held high, DMA_MAX_WAIT=4:
  - Grant sequence alternates cpu, dma, cpu, dma… because of the served mask.
  - wait_cnt never exceeds 1.
  - No master waits more than 1 access.
- dma store addr 31 value 0x12345678, then cpu load addr 31 → cpu_rdata=0x12345678. dma_rdata is unchanged by the cpu read.
- rst_n low during CPU_ACC of a store to addr 5 (prior value 0):
  - No ack.
  - mem_wen=0 that cycle.
  - A subsequent load of addr 5 returns 0.
  - All outputs are 0 after reset.
- cpu drops cpu_req the cycle after its grant → access still completes and cpu_ack pulses once. No second access occurs.
